// File: rtl/mul_unit_pkg.sv
// Shared types for the pipelined RV64M multiplier.
// Op encoding, FSM states, counter width and tree fan-in helper.
package mul_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        MULW   = 3'd4
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    localparam int MAX_STAGES = 4;
    localparam int MUL_CNT_W  = $clog2(MAX_STAGES);

    // Smallest per-level fan-in f with f**levels >= rows, so the
    // adder tree collapses to a single row after `levels` registers.
    function automatic int fan_in(input int rows, input int levels);
        int f;
        int acc;
        for (f = 1; f < rows; f++) begin
            acc = 1;
            for (int l = 0; l < levels; l++) begin
                acc = acc * f;
            end
            if (acc >= rows) break;
        end
        return f;
    endfunction

endpackage

// File: rtl/mul_unit_pp.sv
// Partial-product generator plus the first register level.
// Ports: clk, reset, load, a_sgn, b_sgn, a, b -> rows (ROWS x 2*XLEN).
module mul_pp_array #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16,
    parameter int ROWS  = XLEN / CHUNK + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              a_sgn,
    input  logic              b_sgn,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] rows [ROWS]
);

    logic [2*XLEN-1:0] ax;
    logic [2*XLEN-1:0] ch;
    logic [2*XLEN-1:0] pp [ROWS];

    // B is split into unsigned chunks; a signed B contributes its
    // -2^XLEN weight through the last (correction) row.
    always_comb begin
        ax = '0;
        ax[XLEN-1:0] = a;
        if (a_sgn) ax[2*XLEN-1:XLEN] = {XLEN{a[XLEN-1]}};
        ch = '0;
        for (int i = 0; i < ROWS - 1; i++) begin
            ch = '0;
            ch[CHUNK-1:0] = b[i*CHUNK +: CHUNK];
            pp[i] = (ax * ch) << (i * CHUNK);
        end
        pp[ROWS-1] = '0;
        if (b_sgn & b[XLEN-1]) pp[ROWS-1][2*XLEN-1:XLEN] = -a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) rows[i] <= '0;
        end else if (load) begin
            rows <= pp;
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Pipelined RV64M multiplier: MUL, MULH, MULHSU, MULHU, MULW.
// Ports: clk, reset, valid/ready accept, op, A, B, flush -> done, c, busy.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int CHUNK  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    output logic            ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            done,
    output logic [XLEN-1:0] c,
    output logic            busy
);

    localparam int ROWS = XLEN / CHUNK + 1;
    localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(STAGES - 1);

    mul_state_t            state, nxt;
    logic [MUL_CNT_W-1:0]  cnt, cnt_nxt;
    logic                  accept;
    logic                  a_sgn, b_sgn;
    mul_op_t               op_q;
    logic [2*XLEN-1:0]     pp   [ROWS];
    logic [2*XLEN-1:0]     last [ROWS];
    logic [2*XLEN-1:0]     prod;
    logic [XLEN-1:0]       res;
    logic [XLEN-1:0]       c_hold;

    assign ready  = (state == IDLE) || (state == DONE);
    assign done   = (state == DONE);
    assign busy   = (state != IDLE);
    assign accept = valid & ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    nxt     = (STAGES == 1) ? DONE : BUSY;
                    cnt_nxt = CNT_INIT;
                end else begin
                    nxt = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    nxt = IDLE;
                end else if (cnt <= MUL_CNT_W'(1)) begin
                    nxt     = DONE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign a_sgn = (op == MULH) || (op == MULHSU);
    assign b_sgn = (op == MULH);

    mul_pp_array #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK),
        .ROWS  (ROWS)
    ) u_pp (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .a_sgn (a_sgn),
        .b_sgn (b_sgn),
        .a     (A),
        .b     (B),
        .rows  (pp)
    );

    // Remaining register levels each fold F rows into one; F is
    // chosen so the last level holds the whole product in row 0.
    if (STAGES > 1) begin : g_tree
        localparam int F = fan_in(ROWS, STAGES - 1);
        logic [2*XLEN-1:0] src [STAGES-1][ROWS];
        logic [2*XLEN-1:0] sm  [STAGES-1][ROWS];
        logic [2*XLEN-1:0] tr  [STAGES-1][ROWS];

        always_comb begin
            for (int j = 0; j < ROWS; j++) begin
                src[0][j] = pp[j];
                for (int k = 1; k < STAGES - 1; k++) src[k][j] = tr[k-1][j];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                for (int j = 0; j < ROWS; j++) sm[k][j] = '0;
                for (int i = 0; i < ROWS; i++) begin
                    sm[k][i/F] = sm[k][i/F] + src[k][i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < STAGES - 1; k++)
                    for (int j = 0; j < ROWS; j++) tr[k][j] <= '0;
            end else begin
                tr <= sm;
            end
        end

        assign last = tr[STAGES-2];
    end else begin : g_flat
        assign last = pp;
    end

    always_comb begin
        prod = '0;
        for (int j = 0; j < ROWS; j++) prod = prod + last[j];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= MUL;
        end else if (accept) begin
            op_q <= mul_op_t'(op);
        end
    end

    // Illegal encodings fall into the default (MUL) arm.
    always_comb begin
        unique case (op_q)
            MULH, MULHSU, MULHU: res = prod[2*XLEN-1:XLEN];
            MULW:                res = XLEN'($signed(prod[31:0]));
            default:             res = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_hold <= '0;
        end else if (done) begin
            c_hold <= res;
        end
    end

    assign c = done ? res : c_hold;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: vector table, flush/reset
// sequences, random ops and back-to-back runs on XLEN=32 instances.
module tb_mul_unit;

    localparam int S64 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, flush;
    logic [2:0]  op;
    logic [63:0] A, B;
    logic        ready, done, busy;
    logic [63:0] c;

    logic        v32   [4];
    logic [2:0]  op32  [4];
    logic [31:0] a32   [4];
    logic [31:0] b32   [4];
    logic        rdy32 [4];
    logic        dn32  [4];
    logic        bz32  [4];
    logic [31:0] c32   [4];
    logic        fl32;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_unit #(.XLEN(64), .STAGES(S64), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ready(ready),
        .op(op), .A(A), .B(B), .flush(flush),
        .done(done), .c(c), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_dut32
        mul_unit #(.XLEN(32), .STAGES(g + 1), .CHUNK(16)) u (
            .clk(clk), .reset(reset), .valid(v32[g]), .ready(rdy32[g]),
            .op(op32[g]), .A(a32[g]), .B(b32[g]), .flush(fl32),
            .done(dn32[g]), .c(c32[g]), .busy(bz32[g])
        );
    end

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: extend to xl+1 bits, multiply as mathematical integers.
    function automatic logic [63:0] model(input int xl, input logic [2:0] o,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] m, am, bm, r;
        logic signed [129:0] ea, eb, p;
        m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        am = a & m;
        bm = b & m;
        ea = $signed({66'd0, am});
        eb = $signed({66'd0, bm});
        if ((o == 3'd1 || o == 3'd2) && am[xl-1]) ea = ea - (130'sd1 <<< xl);
        if (o == 3'd1 && bm[xl-1]) eb = eb - (130'sd1 <<< xl);
        p = ea * eb;
        case (o)
            3'd1, 3'd2, 3'd3: r = 64'(p >>> xl);
            3'd4: r = (xl == 64) ? {{32{p[31]}}, p[31:0]} : 64'(p);
            default: r = 64'(p);
        endcase
        return r & m;
    endfunction

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic run_op(input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] exp,
                          input string nm);
        int lat = 0;
        int nd  = 0;
        logic [63:0] cv = '0;
        op = o; A = x; B = y; valid = 1'b1;
        @(negedge clk);
        chk({nm, "_ready_idle"}, 64'(ready), 64'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i < S64) chk({nm, "_ready_busy"}, 64'(ready), 64'd0);
            if (i == S64) chk({nm, "_ready_done"}, 64'(ready), 64'd1);
            if (done) begin
                nd++;
                if (lat == 0) begin
                    lat = i;
                    cv  = c;
                end
            end
        end
        chk({nm, "_latency"}, 64'(lat), 64'(S64));
        chk({nm, "_ndone"}, 64'(nd), 64'd1);
        chk({nm, "_c"}, cv, exp);
        chk({nm, "_hold"}, c, exp);
        @(posedge clk); #1;
    endtask

    task automatic new_vec32(input int g);
        op32[g] = 3'($urandom_range(0, 7));
        a32[g]  = $urandom;
        b32[g]  = $urandom;
    endtask

    // valid stays high; one accept per ready cycle, done every STAGES.
    task automatic b2b(input int g);
        int s    = g + 1;
        int sent = 0;
        int got  = 0;
        logic acc;
        logic [63:0] q[$];
        logic [63:0] e;
        new_vec32(g);
        v32[g] = 1'b1;
        for (int cyc = 0; cyc < 8 * s + 20 && got < 8; cyc++) begin
            @(negedge clk);
            acc = v32[g] && rdy32[g];
            if (dn32[g]) begin
                e = (q.size() > 0) ? q.pop_front() : 64'hDEAD;
                chk($sformatf("b2b_s%0d_c", s), {32'd0, c32[g]}, e);
                chk($sformatf("b2b_s%0d_time", s), 64'(cyc), 64'(s * (got + 1)));
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                q.push_back(model(32, op32[g], {32'd0, a32[g]}, {32'd0, b32[g]}));
                sent++;
                if (sent < 8) new_vec32(g);
                else v32[g] = 1'b0;
            end
        end
        v32[g] = 1'b0;
        chk($sformatf("b2b_s%0d_count", s), 64'(got), 64'd8);
    endtask

    initial begin
        int nd;
        logic [2:0]  o;
        logic [63:0] x, y;

        tv[0]  = '{3'd0, 64'd3, 64'd5, 64'd15, "mul_3x5"};
        tv[1]  = '{3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_ones"};
        tv[2]  = '{3'd1, '1, '1, 64'd0, "mulh_ones"};
        tv[3]  = '{3'd0, '1, '1, 64'd1, "mul_ones"};
        tv[4]  = '{3'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1x2"};
        tv[5]  = '{3'd1, 64'h8000_0000_0000_0000, '1, 64'd0, "mulh_min_m1"};
        tv[6]  = '{3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw_ovf"};
        tv[7]  = '{3'd4, 64'h1_0000_0003, 64'd4, 64'd12, "mulw_hi_ign"};
        tv[8]  = '{3'd5, 64'd6, 64'd7, 64'd42, "illegal_op"};
        tv[9]  = '{3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, "mulhu_2p64"};
        tv[10] = '{3'd2, 64'd2, '1, 64'd1, "mulhsu_2xbig"};

        reset = 1'b1; valid = 1'b0; flush = 1'b0; fl32 = 1'b0;
        op = '0; A = '0; B = '0;
        for (int g = 0; g < 4; g++) begin
            v32[g] = 1'b0; op32[g] = '0; a32[g] = '0; b32[g] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_c", c, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].exp, tv[i].name);

        // Flush in the cycle after accept.
        op = 3'd0; A = 64'd100; B = 64'd3; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        nd = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("flush_ready", 64'(ready), 64'd1);
                chk("flush_busy", 64'(busy), 64'd0);
                chk("flush_hold_c", c, tv[10].exp);
            end
            if (done) nd++;
        end
        chk("flush_no_done", 64'(nd), 64'd0);
        @(posedge clk); #1;
        run_op(3'd0, 64'd6, 64'd7, 64'd42, "after_flush");

        // flush with valid in IDLE must not accept.
        op = 3'd0; A = 64'd5; B = 64'd5; valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        nd = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) chk("idle_flush_busy", 64'(busy), 64'd0);
            if (done) nd++;
        end
        chk("idle_flush_no_done", 64'(nd), 64'd0);
        chk("idle_flush_hold_c", c, 64'd42);
        @(posedge clk); #1;

        // Reset in the cycle after accept.
        op = 3'd0; A = 64'd9; B = 64'd9; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nd = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("midrst_ready", 64'(ready), 64'd1);
                chk("midrst_done", 64'(done), 64'd0);
                chk("midrst_busy", 64'(busy), 64'd0);
                chk("midrst_c", c, 64'd0);
            end
            if (done) nd++;
        end
        chk("midrst_no_done", 64'(nd), 64'd0);
        @(posedge clk); #1;
        run_op(3'd0, 64'd6, 64'd7, 64'd42, "after_reset");

        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 7));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 4 == 1) x[63] = 1'b1;
            if (i % 4 == 2) y[63] = 1'b1;
            run_op(o, x, y, model(64, o, x, y), $sformatf("rand64_op%0d", o));
        end

        for (int g = 0; g < 4; g++) b2b(g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
